// File: rtl/clk_gate_en_ctrl_pkg.sv
// Shared types for the downstream clock-enable controller.
// The state encoding doubles as the state_o debug value.
package clk_gate_en_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HYST = 2'd3
  } clk_gate_state_t;

  localparam logic [1:0] ENC_OFF  = 2'd0;
  localparam logic [1:0] ENC_WAKE = 2'd1;
  localparam logic [1:0] ENC_ON   = 2'd2;
  localparam logic [1:0] ENC_HYST = 2'd3;

  function automatic logic state_clk_en(input clk_gate_state_t s);
    return (s != ST_OFF);
  endfunction

endpackage

// File: rtl/clk_gate_en_ctrl_cnt.sv
// Loadable down-counter that holds at zero instead of wrapping.
module clk_gate_en_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/clk_gate_en_ctrl.sv
// Sequences the enable of a downstream clock gate: wake delay on request,
// idle hysteresis before shutting the clock off again.
//
//   state | meaning
//   OFF   | downstream clock disabled, waiting for wake_req or force_on
//   WAKE  | clock enabled, counting out cfg_wake_dly before declaring ON
//   ON    | clock running, requests acknowledged
//   HYST  | downstream idle, counting out cfg_hyst before turning off
module clk_gate_en_ctrl
  import clk_gate_en_ctrl_pkg::*;
#(
  parameter int HYST_W = 8,
  parameter int DLY_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wake_req,
  input  logic              force_on,
  input  logic              idle,
  input  logic [DLY_W-1:0]  cfg_wake_dly,
  input  logic [HYST_W-1:0] cfg_hyst,
  output logic              clk_en,
  output logic              wake_ack,
  output logic [1:0]        state_o
);

  localparam int CW = (HYST_W > DLY_W) ? HYST_W : DLY_W;

  clk_gate_state_t state, state_nxt;
  logic            cnt_load;
  logic            cnt_dec;
  logic [CW-1:0]   cnt_load_val;
  logic [CW-1:0]   cnt;
  logic            cnt_zero;
  logic            keep_on;

  assign cnt_zero = (cnt == '0);
  assign keep_on  = wake_req | force_on;

  clk_gate_en_ctrl_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .count    (cnt)
  );

  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    case (state)
      ST_OFF: begin
        if (keep_on) begin
          state_nxt    = ST_WAKE;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(cfg_wake_dly);
        end
      end
      ST_WAKE: begin
        if (cnt_zero) state_nxt = ST_ON;
        else          cnt_dec   = 1'b1;
      end
      ST_ON: begin
        if (idle && !keep_on) begin
          state_nxt    = ST_HYST;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(cfg_hyst);
        end
      end
      ST_HYST: begin
        // Any sign of activity beats expiry in the same cycle.
        if (keep_on || !idle) state_nxt = ST_ON;
        else if (cnt_zero)    state_nxt = ST_OFF;
        else                  cnt_dec   = 1'b1;
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  // clk_en comes from next-state so it is a clean flop output aligned with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_OFF;
      clk_en   <= 1'b0;
      wake_ack <= 1'b0;
    end else begin
      state    <= state_nxt;
      clk_en   <= state_clk_en(state_nxt);
      wake_ack <= ((state == ST_ON) || (state == ST_HYST)) && wake_req;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_clk_gate_en_ctrl.sv
// Directed, table-driven bench for clk_gate_en_ctrl with hand-computed expectations.
module tb_clk_gate_en_ctrl;

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_WAKE = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_HYST = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wake_req = 1'b0;
  logic       force_on = 1'b0;
  logic       idle = 1'b0;
  logic [3:0] cfg_wake_dly = 4'd0;
  logic [7:0] cfg_hyst = 8'd0;
  logic       clk_en;
  logic       wake_ack;
  logic [1:0] state_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       wr;
    logic       fo;
    logic       idl;
    logic [3:0] dly;
    logic [7:0] hyst;
    logic [1:0] st;
    logic       en;
    logic       ack;
  } vec_t;

  vec_t vecs[$];

  clk_gate_en_ctrl #(.HYST_W(8), .DLY_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wake_req     (wake_req),
    .force_on     (force_on),
    .idle         (idle),
    .cfg_wake_dly (cfg_wake_dly),
    .cfg_hyst     (cfg_hyst),
    .clk_en       (clk_en),
    .wake_ack     (wake_ack),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic w, input logic f, input logic i,
                              input logic [3:0] d, input logic [7:0] h,
                              input logic [1:0] s, input logic e, input logic a);
    vec_t v;
    v.rst = r; v.wr = w; v.fo = f; v.idl = i; v.dly = d; v.hyst = h;
    v.st = s; v.en = e; v.ack = a;
    vecs.push_back(v);
  endfunction

  initial begin
    // wake with delay 3: enable from cycle 1, ON at 5, ack at 6
    add(1,0,0,0, 3,4, S_OFF, 0,0);
    add(0,1,0,0, 3,4, S_WAKE,1,0);
    add(0,1,0,0, 3,4, S_WAKE,1,0);
    add(0,1,0,0, 3,4, S_WAKE,1,0);
    add(0,1,0,0, 3,4, S_WAKE,1,0);
    add(0,1,0,0, 3,4, S_ON,  1,0);
    add(0,1,0,0, 3,4, S_ON,  1,1);
    add(0,0,0,0, 3,4, S_ON,  1,0);
    // hysteresis 4: five HYST cycles then OFF
    add(0,0,0,1, 3,4, S_HYST,1,0);
    add(0,0,0,1, 3,4, S_HYST,1,0);
    add(0,0,0,1, 3,4, S_HYST,1,0);
    add(0,0,0,1, 3,4, S_HYST,1,0);
    add(0,0,0,1, 3,4, S_HYST,1,0);
    add(0,0,0,1, 3,4, S_OFF, 0,0);
    // zero wake delay, then HYST interrupted at count 2 by activity
    add(0,1,0,0, 0,4, S_WAKE,1,0);
    add(0,1,0,0, 0,4, S_ON,  1,0);
    add(0,0,0,1, 0,4, S_HYST,1,0);
    add(0,0,0,1, 0,4, S_HYST,1,0);
    add(0,0,0,1, 0,4, S_HYST,1,0);
    add(0,0,0,0, 0,4, S_ON,  1,0);
    // zero hysteresis and zero delay round trips
    add(0,0,0,1, 0,0, S_HYST,1,0);
    add(0,0,0,1, 0,0, S_OFF, 0,0);
    add(0,1,0,1, 0,0, S_WAKE,1,0);
    add(0,1,0,1, 0,0, S_ON,  1,0);
    add(0,1,0,1, 0,0, S_ON,  1,1);
    add(0,0,0,1, 0,0, S_HYST,1,0);
    add(0,0,0,1, 0,0, S_OFF, 0,0);
    // reset mid-WAKE with count 5, then late wake_req during WAKE
    add(0,0,1,1, 5,0, S_WAKE,1,0);
    add(1,0,1,1, 5,0, S_OFF, 0,0);
    add(0,0,1,1, 2,0, S_WAKE,1,0);
    add(0,1,0,1, 2,0, S_WAKE,1,0);
    add(0,1,0,1, 2,0, S_WAKE,1,0);
    add(0,1,0,1, 2,0, S_ON,  1,0);
    // reset mid-HYST, then normal OFF evaluation right after
    add(0,0,0,1, 2,3, S_HYST,1,0);
    add(0,0,0,1, 2,3, S_HYST,1,0);
    add(1,0,0,1, 2,3, S_OFF, 0,0);
    add(0,0,0,1, 2,3, S_OFF, 0,0);
    add(0,0,1,1, 2,3, S_WAKE,1,0);

    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst; wake_req = vecs[k].wr; force_on = vecs[k].fo;
      idle = vecs[k].idl; cfg_wake_dly = vecs[k].dly; cfg_hyst = vecs[k].hyst;
      @(posedge clk); #1;
      checks++;
      if (state_o !== vecs[k].st || clk_en !== vecs[k].en || wake_ack !== vecs[k].ack) begin
        errors++;
        $display("FAIL vec%0d: state=%0d clk_en=%0b wake_ack=%0b, want state=%0d clk_en=%0b wake_ack=%0b",
                 k, state_o, clk_en, wake_ack, vecs[k].st, vecs[k].en, vecs[k].ack);
      end
    end

    // force_on held with idle asserted: never OFF, enable stays high
    force_on = 1'b1; idle = 1'b1; wake_req = 1'b0; rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      checks++;
      if (state_o === S_OFF || clk_en !== 1'b1) begin
        errors++;
        $display("FAIL force_hold cyc%0d: state=%0d clk_en=%0b, want state!=0 clk_en=1", c, state_o, clk_en);
      end
    end

    // releasing force_on while idle: ON -> HYST(3) -> OFF in exactly 5 edges
    force_on = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (c < 5 && (state_o !== S_HYST || clk_en !== 1'b1)) begin
        errors++;
        $display("FAIL release cyc%0d: state=%0d clk_en=%0b, want state=3 clk_en=1", c, state_o, clk_en);
      end else if (c == 5 && (state_o !== S_OFF || clk_en !== 1'b0)) begin
        errors++;
        $display("FAIL release_off: state=%0d clk_en=%0b, want state=0 clk_en=0", state_o, clk_en);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_gate_en_ctrl.md
CLK_GATE_EN_CTRL -- requirements
Module: clk_gate_en_ctrl

Interface
REQ-001 SHALL have parameter HYST_W, default 8, width of the idle-hysteresis count.
REQ-002 SHALL have parameter DLY_W, default 4, width of the wake-delay count.
REQ-003 SHALL have port clk, input, 1, the single free-running clock; every register is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-005 SHALL have port wake_req, input, 1, request for the downstream clock; level, held until wake_ack.
REQ-006 SHALL have port force_on, input, 1, override that keeps the clock enabled.
REQ-007 SHALL have port idle, input, 1, downstream-logic idle indication.
REQ-008 SHALL have port cfg_wake_dly, input, DLY_W, cycles spent in WAKE before ON; quasi-static.
REQ-009 SHALL have port cfg_hyst, input, HYST_W, idle cycles tolerated in HYST before OFF; quasi-static.
REQ-010 SHALL have port clk_en, output, 1, registered enable to the downstream clock gate/buffer stage.
REQ-011 SHALL have port wake_ack, output, 1, registered; high while state is ON or HYST and wake_req=1.
REQ-012 SHALL have port state_o, output, 2, current state encoding for debug.

Function
REQ-013 SHALL implement states OFF=0, WAKE=1, ON=2, HYST=3.
REQ-014 SHALL, in OFF, move to WAKE when wake_req|force_on, loading the counter with cfg_wake_dly.
REQ-015 SHALL, in WAKE, move to ON when the counter is 0, and otherwise decrement it by 1.
REQ-016 SHALL, in ON, move to HYST when idle & ~wake_req & ~force_on, loading the counter with cfg_hyst.
REQ-017 SHALL, in HYST, move to ON when wake_req|force_on|~idle; this has priority over expiry.
REQ-018 SHALL, in HYST, otherwise move to OFF when the counter is 0, and otherwise decrement it.
REQ-019 SHALL drive clk_en=1 in WAKE, ON and HYST, and clk_en=0 in OFF.
REQ-020 SHALL register clk_en directly from next-state logic, so it changes only on clk rising edges and is glitch-free.
REQ-021 SHALL, when cfg_wake_dly=0, go OFF->WAKE->ON in 2 cycles; with value N, WAKE lasts N+1 cycles.
REQ-022 SHALL, when cfg_hyst=0, return to OFF one cycle after entering HYST; with value N, HYST lasts N+1 cycles when nothing wakes it.
REQ-023 SHALL have wake_ack rise 1 cycle after state becomes ON, and fall 1 cycle after wake_req deasserts.
REQ-024 SHALL keep the counter saturating at 0 and never wrap below 0.
REQ-025 SHALL treat wake_req rising while in WAKE as having no effect; the current delay completes.
REQ-026 SHALL, on force_on=1 in any state, never reach OFF; an OFF state exits to WAKE on the next edge.

Reset
REQ-027 SHALL, with rst=1, on the next rising edge set state=OFF, counter=0, clk_en=0, wake_ack=0 and state_o=0.
REQ-028 SHALL have reset override all inputs and abort WAKE or HYST mid-count, with no residual count retained.
REQ-029 SHALL, in the first cycle after rst deasserts, evaluate the OFF transitions normally.

Structure
REQ-030 SHALL place the state enum (clk_gate_state_t, 2 bits) and the state encoding constants in package clk_gate_en_ctrl_pkg.
REQ-031 SHALL implement the loadable saturating down-counter, sized max(HYST_W,DLY_W), as one sub-module, clk_gate_en_ctrl_cnt.
REQ-032 SHALL contain no clock-gating cell itself; clk_en feeds the downstream clock gate/buffer stage.

Verification
REQ-033 SHALL cover: rst then wake_req=1, cfg_wake_dly=3 -> clk_en=1 from cycle 1, state ON at cycle 5, wake_ack=1 at cycle 6.
REQ-034 SHALL cover: ON, idle=1, wake_req=0, cfg_hyst=4 -> HYST for 5 cycles, then OFF and clk_en=0.
REQ-035 SHALL cover: HYST with counter=2, then idle=0 -> ON next cycle, clk_en stays 1 throughout.
REQ-036 SHALL cover: cfg_wake_dly=0, cfg_hyst=0 toggling wake_req -> OFF->WAKE->ON in 2 cycles, ON->HYST->OFF in 2 cycles.
REQ-037 SHALL cover: rst asserted mid-WAKE (counter=5) -> OFF, clk_en=0 next edge; mid-HYST likewise.
REQ-038 SHALL cover: force_on=1 with idle=1 for 100 cycles -> state never OFF, clk_en held 1.
